// File: rtl/time_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : time_display_scan
// Description : Four-digit multiplexed seven-segment driver with debounced
//               page button and per-frame coherent snapshot of the BCD inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module time_display_scan #(
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter bit          COMMON_ANODE    = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       page_btn,
    input  logic [3:0] secbcd0,
    input  logic [3:0] secbcd1,
    input  logic [3:0] minbcd0,
    input  logic [3:0] minbcd1,
    input  logic [3:0] hourbcd0,
    input  logic [3:0] hourbcd1,
    input  logic [3:0] daybcd0,
    input  logic [3:0] daybcd1,
    input  logic [3:0] monthbcd,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic [1:0] page
);

    localparam int unsigned        c_div_w    = $clog2(SCAN_DIV);
    localparam int unsigned        c_db_w     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);
    localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);
    localparam logic [c_db_w-1:0]  c_db_last  = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_db_w-1:0]  c_db_one   = c_db_w'(1);

    logic [1:0]         r_sync;
    logic               r_db_level;
    logic [c_db_w-1:0]  r_db_cnt;
    logic [1:0]         r_page;

    logic [c_div_w-1:0] r_div;
    logic [1:0]         r_idx;
    logic [1:0]         r_disp_page;
    logic [3:0]         r_snap_sec0, r_snap_sec1, r_snap_min0, r_snap_min1;
    logic [3:0]         r_snap_hour0, r_snap_hour1, r_snap_day0, r_snap_day1;
    logic [3:0]         r_snap_month;

    logic [6:0]         r_seg_on;
    logic               r_dp_on;
    logic [3:0]         r_an_on;

    logic               w_div_tc;
    logic               w_frame_start;
    logic [3:0]         w_code;
    logic               w_blank;
    logic               w_dp;

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        case (code)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h40;
        endcase
    endfunction

    // Debounced level flips only after the synchronised level has disagreed
    // for DEBOUNCE_CYCLES consecutive cycles; a flip to pressed advances page.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync     <= 2'b00;
            r_db_level <= 1'b0;
            r_db_cnt   <= '0;
            r_page     <= 2'd0;
        end else begin
            r_sync <= {r_sync[0], page_btn};
            if (r_sync[1] == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_db_last) begin
                r_db_cnt   <= '0;
                r_db_level <= r_sync[1];
                if (r_sync[1]) begin
                    r_page <= (r_page == 2'd2) ? 2'd0 : r_page + 2'd1;
                end
            end else begin
                r_db_cnt <= r_db_cnt + c_db_one;
            end
        end
    end

    assign w_div_tc      = (r_div == c_div_last);
    assign w_frame_start = w_div_tc && (r_idx == 2'd3);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_div        <= '0;
            r_idx        <= 2'd0;
            r_disp_page  <= 2'd0;
            r_snap_sec0  <= 4'd0;
            r_snap_sec1  <= 4'd0;
            r_snap_min0  <= 4'd0;
            r_snap_min1  <= 4'd0;
            r_snap_hour0 <= 4'd0;
            r_snap_hour1 <= 4'd0;
            r_snap_day0  <= 4'd0;
            r_snap_day1  <= 4'd0;
            r_snap_month <= 4'd0;
        end else begin
            r_div <= w_div_tc ? '0 : r_div + c_div_one;
            if (w_div_tc) begin
                r_idx <= r_idx + 2'd1;
            end
            if (w_frame_start) begin
                r_disp_page  <= r_page;
                r_snap_sec0  <= secbcd0;
                r_snap_sec1  <= secbcd1;
                r_snap_min0  <= minbcd0;
                r_snap_min1  <= minbcd1;
                r_snap_hour0 <= hourbcd0;
                r_snap_hour1 <= hourbcd1;
                r_snap_day0  <= daybcd0;
                r_snap_day1  <= daybcd1;
                r_snap_month <= monthbcd;
            end
        end
    end

    // Digit content comes only from the snapshot, never from the live inputs.
    always_comb begin
        w_code  = 4'd0;
        w_blank = 1'b0;
        w_dp    = (r_idx == 2'd2);
        case (r_disp_page)
            2'd1: begin
                case (r_idx)
                    2'd3:    w_code = r_snap_min1;
                    2'd2:    w_code = r_snap_min0;
                    2'd1:    w_code = r_snap_sec1;
                    default: w_code = r_snap_sec0;
                endcase
            end
            2'd2: begin
                case (r_idx)
                    2'd3:    w_blank = 1'b1;
                    2'd2:    w_code  = r_snap_month;
                    2'd1:    w_code  = r_snap_day1;
                    default: w_code  = r_snap_day0;
                endcase
            end
            default: begin
                case (r_idx)
                    2'd3: begin
                        w_code  = r_snap_hour1;
                        w_blank = (r_snap_hour1 == 4'd0);
                    end
                    2'd2:    w_code = r_snap_hour0;
                    2'd1:    w_code = r_snap_min1;
                    default: w_code = r_snap_min0;
                endcase
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_seg_on <= 7'h00;
            r_dp_on  <= 1'b0;
            r_an_on  <= 4'h0;
        end else begin
            r_seg_on <= w_blank ? 7'h00 : seg_decode(w_code);
            r_dp_on  <= w_dp;
            r_an_on  <= 4'b0001 << r_idx;
        end
    end

    assign seg  = r_seg_on ^ {7{COMMON_ANODE}};
    assign dp   = r_dp_on ^ COMMON_ANODE;
    assign an   = r_an_on ^ {4{COMMON_ANODE}};
    assign page = r_page;

endmodule
`default_nettype wire

// File: doc/time_display_scan.md
# time_display_scan

Four-digit multiplexed seven-segment driver sitting directly downstream of the BCD clock/calendar counter. It consumes the counter's BCD digit outputs, selects one of three display pages with a debounced push-button, freezes a consistent snapshot once per scan frame, and drives the segment, decimal-point and digit-enable pins of the board display.

## Interface
- SCAN_DIV, 50000: clock cycles each digit stays enabled; legal range 2 and up.
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronised cycles required to accept a button level change; legal range 2 and up.
- COMMON_ANODE, 1: 1 makes seg, dp and an active-low; 0 makes them active-high.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- page_btn  in  1  raw push-button, asynchronous, high = pressed.
- secbcd0, secbcd1, minbcd0, minbcd1, hourbcd0, hourbcd1, daybcd0, daybcd1, monthbcd  in  4 each  live BCD digits from the counter.
- seg  out  7  segments; bit0 = a through bit6 = g.
- dp  out  1  decimal point.
- an  out  4  digit enables; bit3 = leftmost digit. Exactly one is active while scanning.
- page  out  2  current page: 0, 1 or 2.

## Operation
- Button path: 2-flop synchroniser, then debouncer. The counter clears on any cycle where the synchronised level equals the debounced level. Otherwise it increments; when it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
- A debounced rising edge advances page 0→1→2→0. A falling edge does nothing.
- Scan: divider counts 0..SCAN_DIV-1. At the terminal count, digit index idx (0..3) increments and wraps 3→0.
- Frame start is the terminal count with idx=3. At frame start, all nine BCD inputs and the page are copied into a snapshot (disp_page). Display content comes only from the snapshot.
- Page 0, HH.MM:
  - digits 3..0 = hourbcd1, hourbcd0, minbcd1, minbcd0.
  - dp on digit 2.
  - digit 3 is blanked when hourbcd1 = 0.
- Page 1, MM.SS:
  - digits 3..0 = minbcd1, minbcd0, secbcd1, secbcd0.
  - dp on digit 2.
  - no blanking.
- Page 2, month/day:
  - digit 3 blank.
  - digit 2 = monthbcd, with dp.
  - digit 1 = daybcd1; digit 0 = daybcd0.
- Values are shown raw, with no offset applied.
- Decoder, active-high patterns (gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10–15 show a dash, 40.
  - Blank = 00.
- Output inversion for COMMON_ANODE=1 is applied last, to seg, dp and an alike.

## Timing
- Reset values:
  - page=0, disp_page=0, idx=0, divider=0, snapshot all zero.
  - Debounced level released; synchroniser and debounce counter cleared.
  - an, seg and dp all inactive: an=F, seg=7F, dp=1 when COMMON_ANODE=1.
- seg, dp and an are registered. They reflect idx and the snapshot one cycle after either changes.
- First cycle after reset release: an selects digit 0, which shows 0 (page 0, minbcd0).
- Digit period is SCAN_DIV cycles; frame period is 4·SCAN_DIV cycles.
- A new snapshot is visible on digit 0 of the next frame, one cycle after frame start.
- Button latency: page output updates DEBOUNCE_CYCLES+2 cycles after a clean raw rise (2 synchroniser cycles, then the counter). disp_page follows at the next frame start.
- Inputs changing mid-frame, e.g. the counter rolling 23:59→00:00, never produce a mixed frame. The whole frame shows either the old or the new value.
- Bounce shorter than DEBOUNCE_CYCLES produces no page change. Holding the button produces exactly one advance.
- Reset while the button is held: debounced level returns to released. If the button is still held DEBOUNCE_CYCLES+2 cycles after reset release, that counts as a press and page becomes 1.
- Reset mid-frame aborts the frame immediately. Outputs are inactive on the cycle after reset is sampled.

## Test plan
- Reset sweep, SCAN_DIV=4, COMMON_ANODE=1: hold reset 3 cycles → an=F, seg=7F, dp=1, page=0. Next cycle: an=E, seg=40 (digit "0").
- Page 0 with inputs hour=09, min=47, SCAN_DIV=4: after one full frame →
  - digit 3 blank (seg=7F);
  - digit 2 seg inverted 6F=10 with dp=0;
  - digit 1 = "4" (19);
  - digit 0 = "7" (78).
  - Each digit lasts 4 cycles.
- Debounce, DEBOUNCE_CYCLES=8:
  - Raw pulses of 5 high / 3 low ×4 → page stays 0.
  - Then high for 20 cycles → page=1, rising exactly 10 cycles after the stable rise.
  - Hold 100 cycles → page remains 1.
- Page cycling: three clean presses → page 1, 2, 0. On page 2 with monthbcd=3 and day=28 → digits blank, "3"+dp, "2", "8".
- Snapshot coherence: change min from 59 to 00 while idx=1 → remaining digits of the current frame still show 59. Next frame shows 00.
- Invalid BCD: hourbcd0=C on page 0 → digit 2 shows the dash pattern (seg=3F inverted) with dp active.
